cacheline_adaptor: RTL and testbench
====================================

# cacheline_adaptor

Converts single-cycle 256-bit cache-line read/write requests from the cache into 4-beat 64-bit burst transactions on the physical memory port. It sits between the L1 cache (or arbiter) and the burst memory model `ParamMemory`. It is the initiator end of the burst memory protocol that the bench memory answers.

## Interface
- `LINE_WIDTH`, 256, cache-line width in bits
- `BURST_WIDTH`, 64, bits per memory beat
- `ADDR_WIDTH`, 32, address width
- `BURSTS`, LINE_WIDTH/BURST_WIDTH (=4), beats per line; localparam, not overridable

Ports:
- `clk`  in  1  clock; all state updates on posedge
- `rst`  in  1  synchronous, active-high reset
- `line_i`  in  LINE_WIDTH  write data from cache
- `line_o`  out  LINE_WIDTH  read data to cache
- `address_i`  in  ADDR_WIDTH  cache-side line address
- `read_i`  in  1  cache read request, held until `resp_o`
- `write_i`  in  1  cache write request, held until `resp_o`
- `resp_o`  out  1  one-cycle completion pulse to cache
- `burst_i`  in  BURST_WIDTH  read beat from memory
- `burst_o`  out  BURST_WIDTH  write beat to memory
- `address_o`  out  ADDR_WIDTH  line-aligned memory address
- `read_o`  out  1  memory read request
- `write_o`  out  1  memory write request
- `resp_i`  in  1  memory beat strobe

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: on sampled `read_i`, go to READ. On sampled `write_i`, go to WRITE. If both are high, read wins.
- On accept, latch the following and clear the beat counter (2 bits):
  - `address_o <= {address_i[31:5], 5'b0}`
  - for writes, `line_i` into the line buffer
- READ:
  - `read_o` is high.
  - Each cycle with `resp_i`=1 stores `burst_i` into beat slot `cnt`, then increments `cnt`.
  - Beat k maps to bits [64k+63:64k]; beat 0 is the LSBs.
  - When the beat with `cnt`=3 is sampled, go to DONE.
- WRITE:
  - `write_o` is high and `burst_o` = buffer slot `cnt`.
  - Each sampled `resp_i` advances `cnt`. The beat with `cnt`=3 sampled → DONE.
- Gaps: cycles with `resp_i`=0 in READ/WRITE hold state and `cnt`. Gaps between beats are legal.
- DONE: `resp_o`=1 and `read_o`/`write_o`=0. Unconditionally return to IDLE next cycle. `read_i`/`write_i` are ignored in DONE.
- `line_o` drives the buffer. It is valid while `resp_o` is high and stable until the next accepted request.
- `resp_i` sampled in IDLE or DONE is ignored and does not disturb the buffer.
- `address_o` holds its latched value outside transactions.

## Timing
- Reset: state IDLE, `cnt`=0. `resp_o`, `read_o`, `write_o` = 0. `address_o`, `burst_o`, `line_o` = 0; buffer cleared.
- Request sampled at edge T: `read_o`/`write_o` high from T+1.
- Final beat sampled at edge F: `resp_o` high during F+1 only; `read_o`/`write_o` low from F+1.
- Minimum request-to-`resp_o` latency (back-to-back beats, first beat at T+2) is 6 edges.
- Write beat k is presented on `burst_o` until the edge where its `resp_i` is sampled. The next beat appears in the following cycle.
- Next request is accepted at the earliest edge F+2 (IDLE cycle).
- `rst` mid-transaction: the next cycle is IDLE with all outputs at reset values. A partial line is discarded and no `resp_o` is issued.

## Structure
- Shared package `cache_types`:
  - state enum `adaptor_state_t`
  - `LINE_WIDTH`, `BURST_WIDTH`, `BURSTS`, and the offset width (5)
- One natural sub-module: `line_buffer`, a LINE_WIDTH register with
  - full-line load,
  - beat-indexed write (`cnt`, `burst_i`),
  - beat-indexed read mux for `burst_o`.
- FSM, counter and address latch live in the top module.

## Test plan
- Reset: hold `rst` 2 cycles with `read_i`=1 → all outputs 0, no `read_o` until `rst` falls.
- Read, back-to-back beats:
  - Stimulus: `address_i`=0x0000_1234; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44.
  - Response: `address_o`=0x0000_1220; `resp_o` is a single pulse; `line_o`={0x44..,0x33..,0x22..,0x11..}.
- Read, gapped beats: 2-cycle gaps between `resp_i` beats → same `line_o`; `resp_o` exactly one cycle after the 4th beat.
- Write: `line_i`=0xDEAD…0004_0003_0002_0001 pattern → `burst_o` sequence is 64-bit slices 0..3 in order, one per `resp_i`; `resp_o` pulse; `write_o` low after.
- Both `read_i` and `write_i`, plus stray `resp_i` in IDLE:
  - Both requests high → read performed.
  - `resp_i` pulsed in IDLE → no state change and `line_o` unchanged.
- Reset after 2 read beats → IDLE next cycle, no `resp_o`; a subsequent full read completes correctly.

Source files
------------

// File: rtl/cache_types.sv
// Shared types and sizing constants for the cache-line to burst adaptor.
package cache_types;

  localparam int LINE_WIDTH   = 256;
  localparam int BURST_WIDTH  = 64;
  localparam int ADDR_WIDTH   = 32;
  localparam int BURSTS       = LINE_WIDTH / BURST_WIDTH;
  localparam int OFFSET_WIDTH = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor_line_buffer.sv
// One cache line of storage: full-line load for writes, per-beat fill for
// reads, and a beat-indexed read port for the outgoing write burst.
module line_buffer #(
  parameter int LINE_WIDTH  = cache_types::LINE_WIDTH,
  parameter int BURST_WIDTH = cache_types::BURST_WIDTH,
  parameter int CNT_W       = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_i,
  input  logic [LINE_WIDTH-1:0]  line_i,
  input  logic                   beat_we_i,
  input  logic [CNT_W-1:0]       beat_idx_i,
  input  logic [BURST_WIDTH-1:0] beat_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  output logic [BURST_WIDTH-1:0] beat_o
);

  logic [LINE_WIDTH-1:0] buf_q;

  // line storage; load has priority over a beat fill (never both in one state)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_q <= '0;
    end else if (load_i) begin
      buf_q <= line_i;
    end else if (beat_we_i) begin
      buf_q[beat_idx_i*BURST_WIDTH +: BURST_WIDTH] <= beat_i;
    end else begin
      buf_q <= buf_q;
    end
  end

  assign line_o = buf_q;
  assign beat_o = buf_q[beat_idx_i*BURST_WIDTH +: BURST_WIDTH];

endmodule

// File: rtl/cacheline_adaptor.sv
// Converts single-cycle cache-line read/write requests into 4-beat bursts on
// the memory port; completion is signalled with a one-cycle resp_o pulse.
module cacheline_adaptor #(
  parameter int LINE_WIDTH  = cache_types::LINE_WIDTH,
  parameter int BURST_WIDTH = cache_types::BURST_WIDTH,
  parameter int ADDR_WIDTH  = cache_types::ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
);

  localparam int BURSTS   = LINE_WIDTH / BURST_WIDTH;
  localparam int CNT_W    = $clog2(BURSTS);
  localparam int OFFSET_W = $clog2(LINE_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURSTS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  cache_types::adaptor_state_t state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  read_q;
  logic                  write_q;
  logic                  resp_q;
  logic                  load_s;
  logic                  beat_we_s;

  // buffer control: read has priority, so a write is loaded only when read_i is low
  always_comb begin
    load_s    = 1'b0;
    beat_we_s = 1'b0;
    if (state_q == cache_types::ST_IDLE) begin
      load_s = write_i & ~read_i;
    end else if (state_q == cache_types::ST_READ) begin
      beat_we_s = resp_i;
    end else begin
      load_s    = 1'b0;
      beat_we_s = 1'b0;
    end
  end

  // transaction FSM with beat counter, address latch and registered strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= cache_types::ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      case (state_q)
        cache_types::ST_IDLE: begin
          resp_q <= 1'b0;
          if (read_i) begin
            state_q <= cache_types::ST_READ;
            cnt_q   <= '0;
            addr_q  <= {address_i[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
            read_q  <= 1'b1;
          end else if (write_i) begin
            state_q <= cache_types::ST_WRITE;
            cnt_q   <= '0;
            addr_q  <= {address_i[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
            write_q <= 1'b1;
          end else begin
            state_q <= cache_types::ST_IDLE;
          end
        end
        cache_types::ST_READ: begin
          if (resp_i) begin
            cnt_q <= cnt_q + CNT_ONE;
            if (cnt_q == LAST_BEAT) begin
              state_q <= cache_types::ST_DONE;
              read_q  <= 1'b0;
              resp_q  <= 1'b1;
            end
          end
        end
        cache_types::ST_WRITE: begin
          if (resp_i) begin
            cnt_q <= cnt_q + CNT_ONE;
            if (cnt_q == LAST_BEAT) begin
              state_q <= cache_types::ST_DONE;
              write_q <= 1'b0;
              resp_q  <= 1'b1;
            end
          end
        end
        cache_types::ST_DONE: begin
          state_q <= cache_types::ST_IDLE;
          resp_q  <= 1'b0;
        end
        default: begin
          state_q <= cache_types::ST_IDLE;
          cnt_q   <= '0;
          read_q  <= 1'b0;
          write_q <= 1'b0;
          resp_q  <= 1'b0;
        end
      endcase
    end
  end

  line_buffer #(
    .LINE_WIDTH  (LINE_WIDTH),
    .BURST_WIDTH (BURST_WIDTH),
    .CNT_W       (CNT_W)
  ) u_line_buffer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (load_s),
    .line_i     (line_i),
    .beat_we_i  (beat_we_s),
    .beat_idx_i (cnt_q),
    .beat_i     (burst_i),
    .line_o     (line_o),
    .beat_o     (burst_o)
  );

  assign address_o = addr_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign resp_o    = resp_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor; the bench plays both the cache
// and the burst memory, with expected lines/beats held in scoreboard queues.
module tb_cacheline_adaptor;

  logic         clk;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int n_cmp;
  int n_fail;
  logic [255:0] exp_q[$];
  logic [63:0]  beat_q[$];
  logic [255:0] last_line;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; read_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_strobes: read_o=%b write_o=%b resp_o=%b, required 0/0/0", read_o, write_o, resp_o);
      end
      n_cmp++;
      if (address_o !== 32'h0 || burst_o !== 64'h0 || line_o !== 256'h0) begin
        n_fail++;
        $display("FAIL reset_data: address_o=%h burst_o=%h line_o=%h, required all zero", address_o, burst_o, line_o);
      end
    end
    rst = 1'b0; read_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (read_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: read_o=%b, required 0", read_o);
    end
    last_line = 256'h0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [255:0] line, input int gap, input bit both);
    logic [255:0] exp;
    address_i = addr; read_i = 1'b1; write_i = both; line_i = ~line;
    exp_q.push_back(line);
    @(negedge clk);
    n_cmp++;
    if (read_o !== 1'b1 || write_o !== 1'b0) begin
      n_fail++;
      $display("FAIL read_req: read_o=%b write_o=%b, required 1/0", read_o, write_o);
    end
    n_cmp++;
    if (address_o !== {addr[31:5], 5'b00000}) begin
      n_fail++;
      $display("FAIL read_addr: address_o=%h, required %h", address_o, {addr[31:5], 5'b00000});
    end
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gap; g++) begin
        resp_i = 1'b0; burst_i = 64'($urandom());
        @(negedge clk);
        n_cmp++;
        if (resp_o !== 1'b0 || read_o !== 1'b1) begin
          n_fail++;
          $display("FAIL read_gap: resp_o=%b read_o=%b at beat %0d, required 0/1", resp_o, read_o, k);
        end
      end
      resp_i = 1'b1; burst_i = line[64*k +: 64];
      @(negedge clk);
    end
    resp_i = 1'b0; burst_i = 64'($urandom());
    n_cmp++;
    if (resp_o !== 1'b1 || read_o !== 1'b0) begin
      n_fail++;
      $display("FAIL read_resp: resp_o=%b read_o=%b, required 1/0", resp_o, read_o);
    end
    exp = exp_q.pop_front();
    n_cmp++;
    if (line_o !== exp) begin
      n_fail++;
      $display("FAIL read_line: line_o=%h, required %h", line_o, exp);
    end
    read_i = 1'b0; write_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (resp_o !== 1'b0 || line_o !== exp) begin
      n_fail++;
      $display("FAIL read_pulse: resp_o=%b line_o=%h, required 0 and %h", resp_o, line_o, exp);
    end
    last_line = exp;
  endtask

  task automatic test_write(input logic [31:0] addr, input logic [255:0] line, input int gap);
    logic [255:0] exp;
    logic [63:0]  beat;
    address_i = addr; write_i = 1'b1; read_i = 1'b0; line_i = line;
    for (int k = 0; k < 4; k++) beat_q.push_back(line[64*k +: 64]);
    exp_q.push_back(line);
    @(negedge clk);
    line_i = 256'h0;
    n_cmp++;
    if (write_o !== 1'b1 || read_o !== 1'b0 || address_o !== {addr[31:5], 5'b00000}) begin
      n_fail++;
      $display("FAIL write_req: write_o=%b read_o=%b address_o=%h, required 1/0/%h", write_o, read_o, address_o, {addr[31:5], 5'b00000});
    end
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gap; g++) begin
        resp_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (burst_o !== beat_q[0] || write_o !== 1'b1) begin
          n_fail++;
          $display("FAIL write_hold: burst_o=%h write_o=%b at beat %0d, required %h/1", burst_o, write_o, k, beat_q[0]);
        end
      end
      beat = beat_q.pop_front();
      n_cmp++;
      if (burst_o !== beat) begin
        n_fail++;
        $display("FAIL write_beat: burst_o=%h at beat %0d, required %h", burst_o, k, beat);
      end
      resp_i = 1'b1;
      @(negedge clk);
    end
    resp_i = 1'b0;
    n_cmp++;
    if (resp_o !== 1'b1 || write_o !== 1'b0) begin
      n_fail++;
      $display("FAIL write_resp: resp_o=%b write_o=%b, required 1/0", resp_o, write_o);
    end
    exp = exp_q.pop_front();
    n_cmp++;
    if (line_o !== exp) begin
      n_fail++;
      $display("FAIL write_line: line_o=%h, required %h", line_o, exp);
    end
    write_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (resp_o !== 1'b0 || write_o !== 1'b0) begin
      n_fail++;
      $display("FAIL write_pulse: resp_o=%b write_o=%b, required 0/0", resp_o, write_o);
    end
    last_line = exp;
  endtask

  task automatic test_stray_resp();
    resp_i = 1'b1; burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0 || line_o !== last_line) begin
        n_fail++;
        $display("FAIL stray_resp: read_o=%b write_o=%b resp_o=%b line_o=%h, required 0/0/0 and %h",
                 read_o, write_o, resp_o, line_o, last_line);
      end
    end
    resp_i = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    address_i = 32'h0000_8040; read_i = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      resp_i = 1'b1; burst_i = {16{4'h7 + 4'(k)}};
      @(negedge clk);
    end
    resp_i = 1'b0; read_i = 1'b0; rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (read_o !== 1'b0 || resp_o !== 1'b0 || address_o !== 32'h0 || line_o !== 256'h0) begin
      n_fail++;
      $display("FAIL mid_reset: read_o=%b resp_o=%b address_o=%h line_o=%h, required all zero", read_o, resp_o, address_o, line_o);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (resp_o !== 1'b0 || read_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_after: resp_o=%b read_o=%b, required 0/0", resp_o, read_o);
    end
    last_line = 256'h0;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; line_i = 256'h0; address_i = 32'h0;
    read_i = 1'b0; write_i = 1'b0; burst_i = 64'h0; resp_i = 1'b0;
    n_cmp = 0; n_fail = 0;

    test_reset();
    // back-to-back read beats
    do_read(32'h0000_1234, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 0, 1'b0);
    // same line with 2-cycle gaps between beats
    do_read(32'h0000_1234, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 2, 1'b0);
    test_write(32'hABCD_EF7F,
               256'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF_0008_0007_0006_0005_0004_0003_0002_0001, 0);
    test_write(32'h0000_0020,
               256'h1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000, 1);
    // both requests high: read must win
    do_read(32'hFFFF_FFFF, 256'h0102_0304_0506_0708_1112_1314_1516_1718_2122_2324_2526_2728_3132_3334_3536_3738, 0, 1'b1);
    test_stray_resp();
    do_read(32'h1357_9BDF, 256'hA5A5_5A5A_0F0F_F0F0_C3C3_3C3C_9696_6969_1234_5678_9ABC_DEF0_FEDC_BA98_7654_3210, 1, 1'b0);
    test_reset_mid_read();
    do_read(32'h0000_8040, 256'h8888_7777_6666_5555_4444_3333_2222_1111_0000_FFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
